sort_engine_with_merge: RTL and testbench
=========================================

Name: sort_engine_with_merge

Overview:
- Packet sorter: accepts one packet of up to 2**AWIDTH words of DWIDTH bits on a streaming input.
- Words are distributed round-robin over ENGINE_CNT insertion-sort lanes.
- Once the packet ends, the lane contents are merged into one ascending-order output packet of the same length.
- Sits between a packet source and a sink on the sort_engine_if streaming bus. Only one packet is in flight at a time.

Parameters:
- AWIDTH, 6, log2 of maximum packet length (2**AWIDTH words).
- DWIDTH, 8, data word width.
- ENGINE_CNT, 4, number of sort lanes; must be a power of 2 and no greater than 2**AWIDTH. Each lane holds 2**AWIDTH/ENGINE_CNT words.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  synchronous active-high reset.
- pkt_i_data  in  DWIDTH  input word.
- pkt_i_valid  in  1  input word valid.
- pkt_i_sop  in  1  first word of packet.
- pkt_i_eop  in  1  last word of packet.
- pkt_i_ready  out  1  block can accept a word.
- pkt_o_data  out  DWIDTH  sorted output word.
- pkt_o_valid  out  1  output word valid.
- pkt_o_sop  out  1  first output word.
- pkt_o_eop  out  1  last output word.
- pkt_o_ready  in  1  sink accepts the word.

(The pkt_i_* / pkt_o_* groups are the sort_engine_if members, parameterised by DWIDTH.)

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - pkt_o_valid/sop/eop = 0, pkt_o_data = 0, pkt_i_ready = 1.
  - All lane fill counts = 0; state = LOAD; word counter = 0.
  - Reset overrides everything, including a packet in progress in either state; partial data is discarded.
- Handshake: a transfer occurs on a cycle with valid & ready both high. Data, sop and eop are sampled only on transfer.
- State LOAD:
  - pkt_i_ready = 1.
  - Each accepted word goes to lane (word_index mod ENGINE_CNT). word_index counts from 0 within the packet.
  - The lane inserts the word in one cycle: elements greater than the new word shift up one slot, keeping the lane ascending. Equal values keep arrival order (new word after existing equals).
  - A word with sop=1 clears all lanes and restarts word_index at 0; that word becomes element 0.
  - Words after index 2**AWIDTH-1 are dropped (not stored, not counted), but are still accepted.
  - A transfer with eop=1 moves the state to MERGE on the next cycle, provided at least one word is stored. The eop word itself counts as a word.
- State MERGE:
  - pkt_i_ready = 0.
  - Output word = minimum among the heads of non-empty lanes. On ties, the lowest lane index wins.
  - pkt_o_valid = 1 while any lane is non-empty.
  - pkt_o_sop = 1 on the first output word of the packet; pkt_o_eop = 1 when exactly one word remains in total.
  - On each output transfer the winning lane pops its head.
  - Output data/flags are held stable while pkt_o_valid=1 and pkt_o_ready=0.
  - After the eop transfer: state returns to LOAD, pkt_i_ready = 1 on the next cycle, and all lane counts are 0.
- Latency: eop accepted at cycle N → first pkt_o_valid at cycle N+1. Afterwards one word per cycle while pkt_o_ready=1.
- Output length equals the stored word count, at most 2**AWIDTH.
- Comparison is unsigned over DWIDTH bits.
- A packet without sop (e.g. first packet after reset) is accepted normally, because word_index is already 0.

Optional Feature:
- Macro SORT_DESCENDING_EN.
- When defined: lanes keep descending order, merge selects the maximum head, and ties still go to the lowest lane index.
- When undefined: ascending order as above.
- Handshake, latency and sop/eop behaviour are identical in both builds.

Test Plan:
- Packet 5,3,9,1 (sop on 5, eop on 1), pkt_o_ready=1 → output 1,3,5,9; sop on 1, eop on 9; first valid the cycle after eop accept.
- Single word 0x7F with sop=eop=1 → one output 0x7F with sop=eop=1; pkt_i_ready low for exactly the MERGE cycles, then high.
- 64 random words including duplicates, pkt_o_ready toggled randomly → 64 outputs forming the sorted multiset of the inputs; data held stable while stalled.
- 66-word packet → 64 outputs: the sorted first 64 words; words 65 and 66 are dropped.
- sop asserted at word 3 of a load (words 10,20,30 then sop 4,2 eop) → output 2,4 only.
- rst_i asserted mid-MERGE → next cycle pkt_o_valid=0, pkt_i_ready=1; the following packet 8,6 outputs 6,8.

Source files
------------

// File: rtl/sort_engine_if.sv
// Streaming packet bus for sort_engine_with_merge: pkt_i_* carries words into the
// sorter, pkt_o_* carries sorted words out. The DUT uses the slave modport.
interface sort_engine_if #(
  parameter int unsigned DWIDTH = 8
);
  logic [DWIDTH-1:0] pkt_i_data;
  logic              pkt_i_valid;
  logic              pkt_i_sop;
  logic              pkt_i_eop;
  logic              pkt_i_ready;
  logic [DWIDTH-1:0] pkt_o_data;
  logic              pkt_o_valid;
  logic              pkt_o_sop;
  logic              pkt_o_eop;
  logic              pkt_o_ready;

  modport master (
    output pkt_i_data, pkt_i_valid, pkt_i_sop, pkt_i_eop,
    input  pkt_i_ready,
    input  pkt_o_data, pkt_o_valid, pkt_o_sop, pkt_o_eop,
    output pkt_o_ready
  );

  modport slave (
    input  pkt_i_data, pkt_i_valid, pkt_i_sop, pkt_i_eop,
    output pkt_i_ready,
    output pkt_o_data, pkt_o_valid, pkt_o_sop, pkt_o_eop,
    input  pkt_o_ready
  );
endinterface

// File: rtl/sort_engine_with_merge.sv
// Packet sorter: words of one packet are dealt round-robin into ENGINE_CNT
// insertion-sort lanes, then merged into one sorted output packet.
// Build option: define SORT_DESCENDING_EN for descending order (default ascending).
module sort_engine_with_merge #(
  parameter int unsigned AWIDTH     = 6,
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned ENGINE_CNT = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  sort_engine_if.slave bus
);
  localparam int unsigned MaxWords  = 2 ** AWIDTH;
  localparam int unsigned LaneDepth = MaxWords / ENGINE_CNT;
  localparam int unsigned CntW      = AWIDTH + 1;
  localparam int unsigned LselW     = (ENGINE_CNT > 1) ? $clog2(ENGINE_CNT) : 1;

  typedef enum logic [0:0] {StLoad, StMerge} state_e;

  state_e            state_q;
  logic [DWIDTH-1:0] lane_q [ENGINE_CNT][LaneDepth];
  logic [CntW-1:0]   cnt_q [ENGINE_CNT];
  // Stored words: word index while loading, words still to emit while merging.
  logic [CntW-1:0]   word_cnt_q;
  logic              first_q;

  // True when a must be placed after b in the lane / output order.
  function automatic logic after(input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b);
`ifdef SORT_DESCENDING_EN
    return a < b;
`else
    return a > b;
`endif
  endfunction

  logic              in_xfer, out_xfer, store;
  logic [CntW-1:0]   eff_idx, base_cnt;
  logic [LselW-1:0]  tgt_lane, win_lane;
  logic [DWIDTH-1:0] ins_row [LaneDepth];
  logic [DWIDTH-1:0] win_data, cur, prev_val;
  logic              prev_keep, keep, any_valid;

  // Insertion row for the target lane and merge winner selection.
  always_comb begin
    in_xfer   = bus.pkt_i_valid && (state_q == StLoad);
    eff_idx   = bus.pkt_i_sop ? '0 : word_cnt_q;
    store     = in_xfer && (eff_idx < CntW'(MaxWords));
    tgt_lane  = LselW'(eff_idx % CntW'(ENGINE_CNT));
    base_cnt  = bus.pkt_i_sop ? '0 : cnt_q[tgt_lane];
    prev_keep = 1'b1;
    prev_val  = '0;
    cur       = '0;
    keep      = 1'b0;
    // Lane is sorted, so the kept elements form a prefix; the new word lands right
    // after it (after existing equals) and the rest shift up one slot.
    for (int j = 0; j < LaneDepth; j++) begin
      cur  = lane_q[tgt_lane][j];
      keep = (CntW'(j) < base_cnt) && !after(cur, bus.pkt_i_data);
      if (keep)           ins_row[j] = cur;
      else if (prev_keep) ins_row[j] = bus.pkt_i_data;
      else                ins_row[j] = prev_val;
      prev_keep = keep;
      prev_val  = cur;
    end
    any_valid = 1'b0;
    win_lane  = '0;
    win_data  = '0;
    // Strict comparison keeps the lowest lane on ties.
    for (int l = 0; l < ENGINE_CNT; l++) begin
      if (cnt_q[l] != '0 && (!any_valid || after(win_data, lane_q[l][0]))) begin
        any_valid = 1'b1;
        win_lane  = LselW'(l);
        win_data  = lane_q[l][0];
      end
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    bus.pkt_i_ready = (state_q == StLoad);
    bus.pkt_o_valid = (state_q == StMerge) && any_valid;
    bus.pkt_o_data  = bus.pkt_o_valid ? win_data : '0;
    bus.pkt_o_sop   = bus.pkt_o_valid && first_q;
    bus.pkt_o_eop   = bus.pkt_o_valid && (word_cnt_q == CntW'(1));
    out_xfer        = bus.pkt_o_valid && bus.pkt_o_ready;
  end

  // Load/merge FSM together with lane storage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StLoad;
      word_cnt_q <= '0;
      first_q    <= 1'b0;
      for (int l = 0; l < ENGINE_CNT; l++) cnt_q[l] <= '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (in_xfer) begin
            if (bus.pkt_i_sop) begin
              for (int l = 0; l < ENGINE_CNT; l++) cnt_q[l] <= '0;
            end
            if (store) begin
              for (int j = 0; j < LaneDepth; j++) lane_q[tgt_lane][j] <= ins_row[j];
              cnt_q[tgt_lane] <= base_cnt + CntW'(1);
              word_cnt_q      <= eff_idx + CntW'(1);
            end
            if (bus.pkt_i_eop && (store || word_cnt_q != '0)) begin
              state_q <= StMerge;
              first_q <= 1'b1;
            end
          end
        end
        StMerge: begin
          if (out_xfer) begin
            for (int j = 1; j < LaneDepth; j++) lane_q[win_lane][j-1] <= lane_q[win_lane][j];
            cnt_q[win_lane] <= cnt_q[win_lane] - CntW'(1);
            word_cnt_q      <= word_cnt_q - CntW'(1);
            first_q         <= 1'b0;
            if (word_cnt_q == CntW'(1)) state_q <= StLoad;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_engine_with_merge.sv
// Self-checking bench for sort_engine_with_merge: directed table vectors, hand-written
// reset/overflow sequences and random packets against a queue-sort reference model.
module tb_sort_engine_with_merge;
  localparam int AW = 6, DW = 8, EC = 4, MAXW = 2 ** AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sort_engine_if #(.DWIDTH(DW)) bus ();

  sort_engine_with_merge #(.AWIDTH(AW), .DWIDTH(DW), .ENGINE_CNT(EC)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];

  typedef struct {
    int            n;
    logic [DW-1:0] w[8];
    int            sop_at;
    int            ne;
    logic [DW-1:0] e[8];
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: words from the last sop on, first MAXW of them, sorted.
  task automatic build_exp(input int sop_at);
    int start;
    start = (sop_at < 0) ? 0 : sop_at;
    exp_q = {};
    for (int i = start; i < in_q.size() && exp_q.size() < MAXW; i++) exp_q.push_back(in_q[i]);
`ifdef SORT_DESCENDING_EN
    exp_q.rsort();
`else
    exp_q.sort();
`endif
  endtask

  // Sends in_q back to back; eop on the last word. Called at posedge+1.
  task automatic send_pkt(input int sop_at);
    for (int i = 0; i < in_q.size(); i++) begin
      bus.pkt_i_data  = in_q[i];
      bus.pkt_i_sop   = (i == sop_at);
      bus.pkt_i_eop   = (i == in_q.size() - 1);
      bus.pkt_i_valid = 1'b1;
      if (i == 0) check("in_ready_load", bus.pkt_i_ready, 1);
      @(posedge clk); #1;
    end
    bus.pkt_i_valid = 1'b0;
    bus.pkt_i_sop   = 1'b0;
    bus.pkt_i_eop   = 1'b0;
  endtask

  // Drains one output packet starting the cycle after eop accept, compares to exp_q.
  task automatic collect(input bit rand_ready);
    int cyc;
    bit done, stalled;
    logic [DW-1:0] pd;
    logic [1:0] pf;
    cyc = 0; done = 0; stalled = 0; pd = '0; pf = '0;
    got_q = {};
    check("first_valid_latency", bus.pkt_o_valid, 1);
    while (!done && cyc < 2000) begin
      bus.pkt_o_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!bus.pkt_o_valid) begin
        check("out_valid_mid_pkt", bus.pkt_o_valid, 1);
        break;
      end
      check("in_ready_merge", bus.pkt_i_ready, 0);
      if (stalled) begin
        check("hold_data", bus.pkt_o_data, pd);
        check("hold_flags", {bus.pkt_o_sop, bus.pkt_o_eop}, pf);
      end
      check("out_sop", bus.pkt_o_sop, got_q.size() == 0);
      check("out_eop", bus.pkt_o_eop, got_q.size() == exp_q.size() - 1);
      if (bus.pkt_o_ready) begin
        got_q.push_back(bus.pkt_o_data);
        done    = bus.pkt_o_eop;
        stalled = 0;
      end else begin
        stalled = 1;
        pd      = bus.pkt_o_data;
        pf      = {bus.pkt_o_sop, bus.pkt_o_eop};
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.pkt_o_ready = 1'b0;
    if (cyc >= 2000) check("drain_timeout", 0, 1);
    check("out_len", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("out_data", got_q[i], exp_q[i]);
    check("in_ready_after", bus.pkt_i_ready, 1);
    check("valid_after", bus.pkt_o_valid, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{n: 5, w: '{2, 2, 1, 2, 0, 0, 0, 0}, sop_at: -1, ne: 5, e: '{0, 1, 2, 2, 2, 0, 0, 0}};
    tbl[1] = '{n: 4, w: '{5, 3, 9, 1, 0, 0, 0, 0}, sop_at: 0, ne: 4, e: '{1, 3, 5, 9, 0, 0, 0, 0}};
    tbl[2] = '{n: 1, w: '{8'h7f, 0, 0, 0, 0, 0, 0, 0}, sop_at: 0, ne: 1,
               e: '{8'h7f, 0, 0, 0, 0, 0, 0, 0}};
    tbl[3] = '{n: 5, w: '{10, 20, 30, 4, 2, 0, 0, 0}, sop_at: 3, ne: 2, e: '{2, 4, 0, 0, 0, 0, 0, 0}};
    tbl[4] = '{n: 6, w: '{8'hff, 8'h00, 8'h80, 8'h01, 8'hfe, 8'h7f, 0, 0}, sop_at: 0, ne: 6,
               e: '{8'h00, 8'h01, 8'h7f, 8'h80, 8'hfe, 8'hff, 0, 0}};

    bus.pkt_i_data  = '0;
    bus.pkt_i_valid = 1'b0;
    bus.pkt_i_sop   = 1'b0;
    bus.pkt_i_eop   = 1'b0;
    bus.pkt_o_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", bus.pkt_o_valid, 0);
    check("rst_out_data", bus.pkt_o_data, 0);
    check("rst_out_flags", {bus.pkt_o_sop, bus.pkt_o_eop}, 0);
    check("rst_in_ready", bus.pkt_i_ready, 1);
    rst = 1'b0;

    // Directed table; the first vector carries no sop right after reset.
    for (int v = 0; v < 5; v++) begin
      in_q  = {};
      exp_q = {};
      for (int i = 0; i < tbl[v].n; i++) in_q.push_back(tbl[v].w[i]);
      for (int i = 0; i < tbl[v].ne; i++) begin
`ifdef SORT_DESCENDING_EN
        exp_q.push_back(tbl[v].e[tbl[v].ne - 1 - i]);
`else
        exp_q.push_back(tbl[v].e[i]);
`endif
      end
      send_pkt(tbl[v].sop_at);
      collect(0);
    end

    // Full packet with many duplicates and a randomly stalling sink.
    in_q = {};
    for (int i = 0; i < MAXW; i++) in_q.push_back(DW'($urandom_range(0, 15)));
    build_exp(0);
    send_pkt(0);
    collect(1);

    // Overlong packet: the last two words must be dropped.
    in_q = {};
    for (int i = 0; i < MAXW + 2; i++) in_q.push_back(DW'($urandom_range(0, 255)));
    in_q[MAXW]     = 8'h00;
    in_q[MAXW + 1] = 8'hff;
    build_exp(0);
    send_pkt(0);
    collect(0);

    // Random packet lengths and contents.
    for (int p = 0; p < 6; p++) begin
      int len;
      len  = $urandom_range(1, MAXW);
      in_q = {};
      for (int i = 0; i < len; i++) in_q.push_back(DW'($urandom_range(0, 255)));
      build_exp(0);
      send_pkt(0);
      collect(p[0]);
    end

    // Reset in the middle of a merge discards the packet.
    in_q = {9, 1, 7, 3, 5};
    send_pkt(0);
    check("mid_first_valid", bus.pkt_o_valid, 1);
    bus.pkt_o_ready = 1'b1;
    @(posedge clk); #1;
    bus.pkt_o_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", bus.pkt_o_valid, 0);
    check("mid_rst_in_ready", bus.pkt_i_ready, 1);
    in_q = {8, 6};
`ifdef SORT_DESCENDING_EN
    exp_q = {8, 6};
`else
    exp_q = {6, 8};
`endif
    send_pkt(0);
    collect(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
